// File: rtl/eth_tx_mac.sv
// Byte-wide Ethernet transmit MAC: preamble, SFD, header, payload, zero pad, CRC-32 FCS,
// then inter-frame gap. Output bytes are registered; payload is pulled with s_tready.
module eth_tx_mac #(
   parameter logic [7:0]  SFD_BYTE     = 8'hD5,
   parameter int unsigned PREAMBLE_LEN = 7,
   parameter int unsigned MIN_PAYLOAD  = 46,
   parameter int unsigned MAX_PAYLOAD  = 1500,
   parameter int unsigned IFG_LEN      = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [47:0] dest_mac,
   input  logic [47:0] src_mac,
   input  logic [15:0] type_length,
   output logic        busy,
   input  logic [7:0]  s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic        s_tlast,
   output logic [7:0]  m_tdata,
   output logic        m_tvalid,
   output logic        m_tlast,
   output logic        m_terr
);

   localparam logic [7:0]  PreLast = 8'(PREAMBLE_LEN - 1);
   localparam logic [7:0]  IfgLast = 8'(IFG_LEN - 1);
   localparam logic [15:0] MinPay  = 16'(MIN_PAYLOAD);
   localparam logic [15:0] MaxPay  = 16'(MAX_PAYLOAD);

   typedef enum logic [3:0] {
      StIdle, StPreamble, StSfd, StHeader, StPayload, StPad, StAbort, StFcs, StIfg
   } state_e;

   state_e        state;
   logic [7:0]    phase_cnt;
   logic [15:0]   pay_cnt;
   logic [31:0]   crc;
   logic [111:0]  hdr;

   logic [15:0]   pay_nxt;
   logic [7:0]    hdr_byte;
   logic [7:0]    fcs_byte;
   logic [31:0]   crc_inv;

   // Reflected CRC-32, one byte, LSB first.
   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   always_comb begin
      busy     = (state != StIdle);
      s_tready = (state == StPayload);
      pay_nxt  = pay_cnt + 16'd1;
      hdr_byte = hdr[{4'd13 - phase_cnt[3:0], 3'b000} +: 8];
      crc_inv  = ~crc;
      fcs_byte = crc_inv[{phase_cnt[1:0], 3'b000} +: 8];
   end

   // State names the section that supplies the byte registered at the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         phase_cnt <= 8'd0;
         pay_cnt   <= 16'd0;
         crc       <= 32'hFFFFFFFF;
         hdr       <= '0;
         m_tdata   <= 8'd0;
         m_tvalid  <= 1'b0;
         m_tlast   <= 1'b0;
         m_terr    <= 1'b0;
      end else begin
         m_tdata  <= 8'd0;
         m_tvalid <= 1'b1;
         m_tlast  <= 1'b0;
         m_terr   <= 1'b0;
         case (state)
            StIdle: begin
               m_tvalid <= start;
               if (start) begin
                  hdr       <= {dest_mac, src_mac, type_length};
                  m_tdata   <= 8'h55;
                  phase_cnt <= 8'd1;
                  state     <= (PREAMBLE_LEN > 1) ? StPreamble : StSfd;
               end
            end
            StPreamble: begin
               m_tdata   <= 8'h55;
               phase_cnt <= phase_cnt + 8'd1;
               if (phase_cnt == PreLast) state <= StSfd;
            end
            StSfd: begin
               m_tdata   <= SFD_BYTE;
               crc       <= 32'hFFFFFFFF;
               phase_cnt <= 8'd0;
               state     <= StHeader;
            end
            StHeader: begin
               m_tdata   <= hdr_byte;
               crc       <= crc_upd(crc, hdr_byte);
               phase_cnt <= phase_cnt + 8'd1;
               if (phase_cnt == 8'd13) begin
                  pay_cnt <= 16'd0;
                  state   <= StPayload;
               end
            end
            StPayload: begin
               if (s_tvalid) begin
                  m_tdata <= s_tdata;
                  crc     <= crc_upd(crc, s_tdata);
                  pay_cnt <= pay_nxt;
                  if (s_tlast) begin
                     phase_cnt <= 8'd0;
                     state     <= (pay_nxt < MinPay) ? StPad : StFcs;
                  end else if (pay_nxt == MaxPay) begin
                     state <= StAbort;
                  end
               end else begin
                  // Underrun: abort byte goes out on the very next cycle.
                  m_tlast   <= 1'b1;
                  m_terr    <= 1'b1;
                  phase_cnt <= 8'd0;
                  state     <= StIfg;
               end
            end
            StPad: begin
               crc     <= crc_upd(crc, 8'd0);
               pay_cnt <= pay_nxt;
               if (pay_nxt == MinPay) state <= StFcs;
            end
            StAbort: begin
               m_tlast   <= 1'b1;
               m_terr    <= 1'b1;
               phase_cnt <= 8'd0;
               state     <= StIfg;
            end
            StFcs: begin
               m_tdata   <= fcs_byte;
               phase_cnt <= phase_cnt + 8'd1;
               if (phase_cnt == 8'd3) begin
                  m_tlast   <= 1'b1;
                  phase_cnt <= 8'd0;
                  state     <= StIfg;
               end
            end
            StIfg: begin
               m_tvalid  <= 1'b0;
               phase_cnt <= phase_cnt + 8'd1;
               if (phase_cnt == IfgLast) state <= StIdle;
            end
            default: begin
               m_tvalid <= 1'b0;
               state    <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_tx_mac.sv
// Scoreboard bench for eth_tx_mac: expected wire bytes are queued as stimulus is driven
// and popped as the DUT emits them; received frames also get an FCS residue check.
module tb_eth_tx_mac;

   localparam int MaxPay = 1500;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [47:0] dest_mac = '0;
   logic [47:0] src_mac = '0;
   logic [15:0] type_length = '0;
   logic        busy;
   logic [7:0]  s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        s_tlast = 1'b0;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tlast;
   logic        m_terr;

   eth_tx_mac dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dest_mac    (dest_mac),
      .src_mac     (src_mac),
      .type_length (type_length),
      .busy        (busy),
      .s_tdata     (s_tdata),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .s_tlast     (s_tlast),
      .m_tdata     (m_tdata),
      .m_tvalid    (m_tvalid),
      .m_tlast     (m_tlast),
      .m_terr      (m_terr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       err;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int unsigned cyc = 0;
   logic [31:0] gen_crc = 32'hFFFFFFFF;

   int          mon_idx = 0;
   logic [31:0] mon_crc = 32'hFFFFFFFF;
   int          last_len = 0;
   int unsigned tlast_cyc = 0;
   int unsigned last_gap = 0;
   logic        seen_tlast = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_byte(input logic [7:0] d, input logic l, input logic e, input logic in_crc);
      exp_q.push_back(exp_t'{data: d, last: l, err: e});
      if (in_crc) gen_crc = crc8(gen_crc, d);
   endtask

   task automatic push_header();
      logic [111:0] h;
      h = {dest_mac, src_mac, type_length};
      for (int i = 0; i < 7; i++) push_byte(8'h55, 1'b0, 1'b0, 1'b0);
      push_byte(8'hD5, 1'b0, 1'b0, 1'b0);
      gen_crc = 32'hFFFFFFFF;
      for (int i = 0; i < 14; i++) begin
         push_byte(h[111:104], 1'b0, 1'b0, 1'b1);
         h = h << 8;
      end
   endtask

   task automatic push_tail(input int n);
      logic [31:0] f;
      for (int k = n; k < 46; k++) push_byte(8'h00, 1'b0, 1'b0, 1'b1);
      f = ~gen_crc;
      for (int k = 0; k < 4; k++) begin
         push_byte(f[7:0], k == 3, 1'b0, 1'b0);
         f = f >> 8;
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while (busy && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic start_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                              input logic hold);
      wait_idle();
      dest_mac    = d;
      src_mac     = s;
      type_length = t;
      start       = 1'b1;
      push_header();
      if (!hold) begin
         @(posedge clk);
         #1 start = 1'b0;
      end
   endtask

   // stop_at >= 0 drops s_tvalid after that many accepted bytes (underrun).
   task automatic drive_payload(input int len, input int stop_at, input logic give_last,
                                input int seed, input logic drop_start, output int accepted);
      int t;
      accepted = 0;
      for (int i = 0; i < len; i++) begin
         if (i == stop_at) break;
         s_tdata  = 8'(seed + i);
         s_tvalid = 1'b1;
         s_tlast  = give_last && (i == len - 1);
         t = 0;
         @(negedge clk);
         while (!s_tready && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (!s_tready) break;
         if (drop_start) start = 1'b0;
         @(posedge clk);
         #1;
         accepted++;
         push_byte(s_tdata, 1'b0, 1'b0, 1'b1);
         if (accepted == MaxPay && !s_tlast) push_byte(8'h00, 1'b1, 1'b1, 1'b0);
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_idx = 0;
      end else if (m_tvalid) begin
         if (mon_idx == 0) begin
            if (seen_tlast) last_gap = cyc - tlast_cyc;
            mon_crc = 32'hFFFFFFFF;
         end
         if (mon_idx >= 8) mon_crc = crc8(mon_crc, m_tdata);
         if (exp_q.size() == 0) begin
            check_eq("extra_byte", 32'(exp_q.size()), 32'd1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("m_tdata", 32'(m_tdata), 32'(e.data));
            check_eq("m_tlast", 32'(m_tlast), 32'(e.last));
            check_eq("m_terr", 32'(m_terr), 32'(e.err));
         end
         mon_idx++;
         if (m_tlast) begin
            last_len   = mon_idx;
            tlast_cyc  = cyc;
            seen_tlast = 1'b1;
            if (!m_terr) check_eq("fcs_residue", mon_crc, 32'hDEBB20E3);
            mon_idx = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got hang expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  acc;
      logic flag, flag2;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_m_tdata", 32'(m_tdata), 32'd0);
      check_eq("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      check_eq("rst_m_tlast", 32'(m_tlast), 32'd0);
      check_eq("rst_m_terr", 32'(m_terr), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_s_tready", 32'(s_tready), 32'd0);
      rst_n = 1'b1;

      // Minimum frame, 46 bytes 00..2D
      start_frame(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 1'b0);
      drive_payload(46, -1, 1'b1, 0, 1'b0, acc);
      push_tail(acc);
      wait_idle();
      check_eq("min_accepted", 32'(acc), 32'd46);
      check_eq("min_len", 32'(last_len), 32'd72);

      // Short payload padded to minimum
      start_frame(48'h0011_2233_4455, 48'h0200_0000_0002, 16'h86DD, 1'b0);
      drive_payload(10, -1, 1'b1, 8'hA0, 1'b0, acc);
      push_tail(acc);
      wait_idle();
      check_eq("pad_len", 32'(last_len), 32'd72);

      // Underrun after 20 bytes
      start_frame(48'h0A0B_0C0D_0E0F, 48'h0200_0000_0003, 16'h0800, 1'b0);
      drive_payload(46, 20, 1'b1, 8'h30, 1'b0, acc);
      push_byte(8'h00, 1'b1, 1'b1, 1'b0);
      check_eq("under_accepted", 32'(acc), 32'd20);
      flag = 1'b0;
      for (int i = 0; i < 50 && !flag; i++) begin
         @(negedge clk);
         if (m_tvalid && m_tlast) flag = 1'b1;
      end
      check_eq("under_abort_seen", 32'(flag), 32'd1);
      flag = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (m_tvalid) flag = 1'b1;
      end
      check_eq("under_ifg_idle", 32'(flag), 32'd0);
      @(negedge clk);
      check_eq("under_busy_after_ifg", 32'(busy), 32'd0);

      // Back-to-back with start held high
      start_frame(48'h1111_2222_3333, 48'h0200_0000_0004, 16'h0800, 1'b1);
      drive_payload(46, -1, 1'b1, 8'h40, 1'b0, acc);
      push_tail(acc);
      push_header();
      drive_payload(50, -1, 1'b1, 8'h80, 1'b1, acc);
      push_tail(acc);
      wait_idle();
      check_eq("b2b_start_low", 32'(start), 32'd0);
      check_eq("b2b_gap", last_gap, 32'd13);
      check_eq("b2b_len", 32'(last_len), 32'd76);

      // Overrun: 1501 bytes offered, no s_tlast
      start_frame(48'h0000_0000_0001, 48'h0200_0000_0005, 16'h0800, 1'b0);
      drive_payload(MaxPay, -1, 1'b0, 8'h05, 1'b0, acc);
      check_eq("over_accepted", 32'(acc), 32'(MaxPay));
      s_tdata  = 8'hEE;
      s_tvalid = 1'b1;
      flag  = 1'b0;
      flag2 = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (s_tready) flag = 1'b1;
         if (m_tvalid && m_tlast && m_terr) flag2 = 1'b1;
      end
      s_tvalid = 1'b0;
      check_eq("over_ready_dropped", 32'(flag), 32'd0);
      check_eq("over_abort_seen", 32'(flag2), 32'd1);
      wait_idle();

      // s_tlast on the 1500th byte is a valid frame
      start_frame(48'h0000_0000_0002, 48'h0200_0000_0006, 16'h05DC, 1'b0);
      drive_payload(MaxPay, -1, 1'b1, 8'h11, 1'b0, acc);
      push_tail(acc);
      wait_idle();
      check_eq("max_len", 32'(last_len), 32'd1526);

      // Reset pulse mid-header, then a clean frame
      start_frame(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0007, 16'h0800, 1'b0);
      repeat (13) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_m_tdata", 32'(m_tdata), 32'd0);
      check_eq("mid_rst_m_tvalid", 32'(m_tvalid), 32'd0);
      check_eq("mid_rst_m_tlast", 32'(m_tlast), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_s_tready", 32'(s_tready), 32'd0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      start_frame(48'h0123_4567_89AB, 48'h0200_0000_0008, 16'h0806, 1'b0);
      drive_payload(60, -1, 1'b1, 8'h77, 1'b0, acc);
      push_tail(acc);
      wait_idle();
      check_eq("post_rst_len", 32'(last_len), 32'd86);

      repeat (5) @(negedge clk);
      check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_tx_mac.md
Name: eth_tx_mac

Overview:
- Byte-wide Ethernet MAC transmitter and frame encoder. It is the transmit-side counterpart of the RX MAC/decoder.
- Accepts a header descriptor (destination MAC, source MAC, type/length) and a payload byte stream.
- Emits a complete wire frame: preamble, SFD, header, payload, zero padding to minimum size, and CRC-32 FCS.
- After each frame it enforces the inter-frame gap. Sits between the order/market-data packet builder and the PHY-side byte interface.

Parameters:
- SFD_BYTE, 8'hD5, start-frame-delimiter byte emitted after the preamble.
- PREAMBLE_LEN, 7, number of 8'h55 preamble bytes.
- MIN_PAYLOAD, 46, minimum payload bytes; shorter payloads are zero-padded.
- MAX_PAYLOAD, 1500, maximum payload bytes accepted before forced abort.
- IFG_LEN, 12, idle cycles after m_tlast before the next start is accepted.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame request, sampled only in IDLE
- dest_mac  in  48  destination MAC, latched on accepted start, sent MSB byte first
- src_mac  in  48  source MAC, latched on accepted start, sent MSB byte first
- type_length  in  16  EtherType/length, latched on accepted start, sent MSB byte first
- busy  out  1  high in every state except IDLE
- s_tdata  in  8  payload byte
- s_tvalid  in  1  payload byte valid
- s_tready  out  1  payload byte accepted when s_tvalid && s_tready
- s_tlast  in  1  marks last payload byte
- m_tdata  out  8  wire byte
- m_tvalid  out  1  wire byte valid; no backpressure, the PHY consumes every cycle
- m_tlast  out  1  last byte of frame (last FCS byte, or abort byte)
- m_terr  out  1  frame aborted; asserted together with m_tlast on the abort byte

Behaviour:
- Reset (rst_n low, asynchronous):
  - state returns to IDLE.
  - m_tdata=0, m_tvalid=0, m_tlast=0, m_terr=0, busy=0, s_tready=0.
  - All counters are cleared. CRC is set to 32'hFFFFFFFF.
  - Reset mid-frame truncates the output immediately. No m_tlast is generated.
- m_tdata, m_tvalid, m_tlast and m_terr are registered. s_tready is combinational: it is 1 only in PAYLOAD.
- IDLE:
  - start=1 latches the header fields and moves to PREAMBLE.
  - The first 8'h55 appears on m_tdata, with m_tvalid=1, on the cycle after start is sampled.
  - start is ignored while busy.
- PREAMBLE: emits PREAMBLE_LEN bytes of 8'h55, then goes to SFD.
- SFD: emits SFD_BYTE for one cycle, then goes to HEADER.
- HEADER:
  - Emits 14 bytes: dest_mac[47:40] first ... type_length[7:0] last.
  - CRC is initialised to FFFFFFFF at entry and updated on every header byte.
- PAYLOAD:
  - Each accepted s_tdata byte appears on m_tdata the next cycle, and CRC is updated. A 16-bit payload counter increments per accepted byte.
  - On s_tlast accepted: if count < MIN_PAYLOAD, go to PAD; otherwise go to FCS.
  - Underrun: s_tvalid=0 in any PAYLOAD cycle aborts the frame. The next cycle emits m_tdata=0 with m_tvalid=1, m_tlast=1, m_terr=1, then the block goes to IFG.
  - Overrun: accepting byte number MAX_PAYLOAD with s_tlast=0 forces the same abort on the following cycle. The block then drops input: s_tready stays 0 until the next frame.
- PAD: emits 8'h00 bytes, each included in the CRC, until payload plus pad equals MIN_PAYLOAD, then goes to FCS.
- FCS:
  - Emits the 4 bytes of ~CRC, least-significant byte first. m_tlast is asserted on the 4th byte.
  - CRC-32 uses the reflected form, polynomial 32'hEDB88320, processing each byte LSB first.
- IFG: m_tvalid=0 for IFG_LEN cycles, busy=1, then IDLE. Aborted frames also pass through IFG.
- m_tvalid is continuous (high every cycle) from the first preamble byte through m_tlast.
- Simultaneous s_tlast and the MAX_PAYLOAD-th byte: the frame is treated as valid (FCS path, no abort).
- Frame length on the wire = 8 + 14 + max(payload, 46) + 4.

Test Plan:
- Min frame:
  - Stimulus: start with dest=FF:FF:FF:FF:FF:FF, src=02:00:00:00:00:01, type=0800, 46 payload bytes 00..2D, s_tlast on 2D.
  - Required: 72 valid bytes. Bytes 0-6 are 55, byte 7 is D5, bytes 8-13 are FF, bytes 20-21 are 08 00. m_tlast on byte 71.
  - Running reflected CRC over bytes 8..71 equals residue 32'hDEBB20E3.
- Padding: 10-byte payload.
  - Required: 36 zero pad bytes follow the payload, total 72 bytes, and the FCS residue check passes.
- Underrun: s_tvalid dropped after 20 payload bytes.
  - Required: next cycle m_tdata=00 with m_tlast=1 and m_terr=1, then 12 cycles of m_tvalid=0, then busy=0.
- Back-to-back: start held high continuously.
  - Required: the second frame's first 55 appears exactly 13 cycles after the first frame's m_tlast. start is ignored during busy.
- Overrun: 1501 bytes offered with no s_tlast.
  - Required: 1500 bytes accepted, then an abort byte with m_terr=1. s_tready stays 0 afterwards.
- Reset mid-HEADER: rst_n pulsed low.
  - Required: all outputs drop to 0 asynchronously. A new start produces a clean frame that passes the CRC residue check.
